// File: rtl/vyapaar_pkg.sv
// Shared types and default sizing for the covariance estimator blocks.
package vyapaar_pkg;

    localparam int unsigned DEF_WIDTH       = 16;
    localparam int unsigned DEF_FRACT       = 8;
    localparam int unsigned DEF_N_STOCKS    = 4;
    localparam int unsigned DEF_LOG_SAMPLES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } cov_state_e;

endpackage

// File: rtl/cov_finalize.sv
// Combinational finalisation of one covariance pair from its window sums.
// Optional macro: COV_SATURATE_EN (clamp instead of wrap on WIDTH overflow).
module cov_finalize
    import vyapaar_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned FRACT       = DEF_FRACT,
    parameter int unsigned LOG_SAMPLES = DEF_LOG_SAMPLES,
    parameter int unsigned ACC_W       = 2*WIDTH + LOG_SAMPLES
) (
    input  logic signed [ACC_W-1:0] i_sum_xi,
    input  logic signed [ACC_W-1:0] i_sum_xj,
    input  logic signed [ACC_W-1:0] i_sum_xy,
    output logic signed [WIDTH-1:0] o_cov
);

    logic signed [ACC_W-1:0] w_mean_i;
    logic signed [ACC_W-1:0] w_mean_j;
    logic signed [ACC_W-1:0] w_prod;
    logic signed [ACC_W-1:0] w_exy;

    // Means fit in WIDTH bits, so their product cannot overflow ACC_W.
    assign w_mean_i = i_sum_xi >>> LOG_SAMPLES;
    assign w_mean_j = i_sum_xj >>> LOG_SAMPLES;
    assign w_prod   = w_mean_i * w_mean_j;
    assign w_exy    = i_sum_xy >>> (LOG_SAMPLES + FRACT);

`ifdef COV_SATURATE_EN
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [ACC_W-1:0] w_diff;

    assign w_diff = w_exy - (w_prod >>> FRACT);

    always_comb begin
        o_cov = w_diff[WIDTH-1:0];
        if (w_diff > MAX_V) begin
            o_cov = MAX_V[WIDTH-1:0];
        end else if (w_diff < MIN_V) begin
            o_cov = MIN_V[WIDTH-1:0];
        end
    end
`else
    assign o_cov = WIDTH'(w_exy - (w_prod >>> FRACT));
`endif

endmodule

// File: rtl/cov_estimator.sv
// Covariance estimator: accumulates 2^LOG_SAMPLES return vectors, then finalises
// the upper triangle one pair per cycle. Optional macro: COV_SATURATE_EN.
module cov_estimator
    import vyapaar_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned FRACT       = DEF_FRACT,
    parameter int unsigned N_STOCKS    = DEF_N_STOCKS,
    parameter int unsigned LOG_SAMPLES = DEF_LOG_SAMPLES
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    start_in,
    input  logic signed [WIDTH-1:0] returns_in [N_STOCKS],
    input  logic                    valid_in,
    output logic                    ready_out,
    output logic signed [WIDTH-1:0] matrix_out [N_STOCKS][N_STOCKS],
    output logic                    valid_out,
    input  logic                    ready_in
);

    localparam int unsigned ACC_W  = 2*WIDTH + LOG_SAMPLES;
    localparam int unsigned PROD_W = 2*WIDTH;
    localparam int unsigned CNT_W  = LOG_SAMPLES + 1;
    localparam int unsigned IDX_W  = (N_STOCKS > 1) ? $clog2(N_STOCKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG_SAMPLES) - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STOCKS - 1);

    cov_state_e r_state;
    cov_state_e w_state_nxt;

    logic                    r_ready;
    logic                    r_valid;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_pi;
    logic [IDX_W-1:0]        r_pj;
    logic signed [ACC_W-1:0] r_sum_x  [N_STOCKS];
    logic signed [ACC_W-1:0] r_sum_xy [N_STOCKS][N_STOCKS];
    logic signed [WIDTH-1:0] r_matrix [N_STOCKS][N_STOCKS];

    logic                     w_accept;
    logic                     w_last_pair;
    logic signed [PROD_W-1:0] w_xprod [N_STOCKS][N_STOCKS];
    logic signed [WIDTH-1:0]  w_cov;

    assign ready_out  = r_ready;
    assign valid_out  = r_valid;
    assign matrix_out = r_matrix;

    // State register.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last_pair = (r_pi == LAST_IDX) && (r_pj == LAST_IDX);
        case (r_state)
            IDLE: begin
                if (start_in) begin
                    w_state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                w_accept = valid_in;
                if (valid_in && (r_cnt == LAST_CNT)) begin
                    w_state_nxt = FINAL;
                end
            end
            FINAL: begin
                if (w_last_pair) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (ready_in) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake outputs registered from the next state so they track r_state exactly.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_ready <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_ready <= (w_state_nxt == ACCUM);
            r_valid <= (w_state_nxt == DONE);
        end
    end

    // Per-sample cross products for the accumulation phase.
    always_comb begin
        for (int i = 0; i < int'(N_STOCKS); i++) begin
            for (int j = 0; j < int'(N_STOCKS); j++) begin
                w_xprod[i][j] = PROD_W'(returns_in[i]) * PROD_W'(returns_in[j]);
            end
        end
    end

    cov_finalize #(
        .WIDTH       (WIDTH),
        .FRACT       (FRACT),
        .LOG_SAMPLES (LOG_SAMPLES),
        .ACC_W       (ACC_W)
    ) u_finalize (
        .i_sum_xi (r_sum_x[r_pi]),
        .i_sum_xj (r_sum_x[r_pj]),
        .i_sum_xy (r_sum_xy[r_pi][r_pj]),
        .o_cov    (w_cov)
    );

    // Accumulators, pair walker and result matrix.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_cnt <= '0;
            r_pi  <= '0;
            r_pj  <= '0;
            for (int i = 0; i < int'(N_STOCKS); i++) begin
                r_sum_x[i] <= '0;
                for (int j = 0; j < int'(N_STOCKS); j++) begin
                    r_sum_xy[i][j] <= '0;
                    r_matrix[i][j] <= '0;
                end
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_in) begin
                        r_cnt <= '0;
                        r_pi  <= '0;
                        r_pj  <= '0;
                        for (int i = 0; i < int'(N_STOCKS); i++) begin
                            r_sum_x[i] <= '0;
                            for (int j = 0; j < int'(N_STOCKS); j++) begin
                                r_sum_xy[i][j] <= '0;
                            end
                        end
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        for (int i = 0; i < int'(N_STOCKS); i++) begin
                            r_sum_x[i] <= r_sum_x[i] + ACC_W'(returns_in[i]);
                            for (int j = 0; j < int'(N_STOCKS); j++) begin
                                if (j >= i) begin
                                    r_sum_xy[i][j] <= r_sum_xy[i][j] + ACC_W'(w_xprod[i][j]);
                                end
                            end
                        end
                    end
                end
                FINAL: begin
                    r_matrix[r_pi][r_pj] <= w_cov;
                    r_matrix[r_pj][r_pi] <= w_cov;
                    // Row-major walk over the upper triangle.
                    if (r_pj == LAST_IDX) begin
                        r_pi <= r_pi + IDX_W'(1);
                        r_pj <= r_pi + IDX_W'(1);
                    end else begin
                        r_pj <= r_pj + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
